button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Upstream input stage for the digital lock: conditions N raw pushbuttons into
//   clean, debounced levels and single-cycle press pulses.
//   Per button: 2-FF synchroniser, counter-based debouncer, rising-edge one-shot.
//   btn_pulse feeds the lock FSM's z[] vector directly: one pulse per physical press.
// PARAMETERS
//   N_BTN            4        number of independent button channels
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles before a level change is accepted (>=1; 5 ms @ 100 MHz)
// PORTS
//   clk        in   1      system clock
//   rst        in   1      asynchronous, active-high reset
//   btn_in     in   N_BTN  raw asynchronous button inputs, 1 = pressed
//   btn_level  out  N_BTN  debounced button level
//   btn_pulse  out  N_BTN  one-cycle pulse on each debounced 0->1 transition
//   any_held   out  1      OR of btn_level
//   multi      out  1      1 when more than one btn_pulse bit is high in the same cycle
// BEHAVIOUR
//   Clock/reset: one clock (clk); rst is asynchronous and active-high, clears every register.
//   Reset values: btn_level=0, btn_pulse=0, any_held=0, multi=0; sync FFs, counters, db_d = 0.
//   Per channel i (all channels identical, fully independent):
//   - sync1 <= btn_in[i]; sync2 <= sync1.
//   - Counter cnt, width $clog2(DEBOUNCE_CYCLES)+1; never wraps.
//     sync2 == db: cnt <= 0.
//     sync2 != db, cnt == DEBOUNCE_CYCLES-1: db <= sync2, cnt <= 0.
//     sync2 != db otherwise: cnt <= cnt+1.
//   - btn_level[i] = db; db_d <= db; btn_pulse[i] = db & ~db_d (combinational from regs).
//   Latency: btn_in rises before edge 1 and stays high -> db=1 after edge DEBOUNCE_CYCLES+2;
//     btn_pulse high for exactly the following cycle (until edge DEBOUNCE_CYCLES+3).
//   Release: symmetric debounce on the 1->0 level change; no pulse on release.
//   Bounce: any single-cycle return of sync2 to db restarts the count from 0.
//   Held button: exactly one pulse per accepted 0->1 change, regardless of hold time.
//   Simultaneous presses: each channel pulses independently; multi=1 in that cycle.
//     Downstream treats it as an invalid pattern; no arbitration here.
//   Reset mid-operation: all state cleared immediately (async).
//     A button held across reset release is treated as a new press:
//     pulse DEBOUNCE_CYCLES+2 edges after reset deasserts.
//   any_held = |btn_level; multi = popcount(btn_pulse) > 1; both combinational from regs.
// TESTING (DEBOUNCE_CYCLES=4, N_BTN=4)
//   1 clean press: btn_in=0001 held 20 cycles -> btn_level[0]=1 after edge 6;
//     btn_pulse=0001 for one cycle only; multi=0.
//   2 bounce: btn_in[1] high 3 cycles, low 1, high 10 -> no pulse from the first burst;
//     single pulse 6 edges after the final rise.
//   3 release: after test 1, btn_in=0000 -> btn_level[0] falls 6 edges later;
//     btn_pulse stays 0000 throughout.
//   4 simultaneous: btn_in 0000->1100 at the same edge -> btn_pulse=1100 for one cycle;
//     multi=1 in that cycle only.
//   5 reset mid-count: btn_in[2]=1; assert rst after 3 edges, release, keep held ->
//     all outputs 0 during reset; one pulse 6 edges after release.
//   6 glitch reject: 1-cycle and 3-cycle high blips on btn_in[3] -> btn_level and
//     btn_pulse never change; any_held stays 0.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button conditioner port bundle: raw pushbutton inputs in, and the debounced levels,
// press pulses and summary flags out.
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic             any_held;
  logic             multi;

  modport master (
    output btn_in,
    input  btn_level, btn_pulse, any_held, multi
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_pulse, any_held, multi
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button 2-FF synchroniser, counter debouncer and rising-edge one-shot; the pulses
// drive the lock FSM's z[] inputs, with one pulse for each physical press.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] db_q, db_d;
  logic [N_BTN-1:0] db_prev_q;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] pulse;

  // Any cycle where the synchronised input agrees with the accepted level restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.btn_in;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pulse         = db_q & ~db_prev_q;
  assign bus.btn_level = db_q;
  assign bus.btn_pulse = pulse;
  assign bus.any_held  = |db_q;
  // More than one bit set <=> clearing the lowest set bit leaves something behind.
  assign bus.multi     = (pulse & (pulse - N_BTN'(1))) != '0;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed press/bounce/release/reset scenarios and a
// randomized phase, checked every cycle against a sample-history reference model.
module tb_button_conditioner;
  localparam int N  = 4;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_conditioner_if #(.N_BTN(N)) bus ();

  button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: raw input samples taken at each clock edge. A level changes when
  // the DC most recent samples that have crossed the 2-edge synchroniser all disagree
  // with it. Samples from before reset count as 0.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] m_lvl, m_prev;

  int pulse_seen [N];
  int multi_seen;
  int any_seen;

  function automatic void model_reset();
    raw_q.delete();
    for (int k = 0; k < DC + 2; k++) raw_q.push_back('0);
    m_lvl  = '0;
    m_prev = '0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] s);
    logic [N-1:0] nxt;
    bit           all_diff;
    raw_q.push_back(s);
    m_prev = m_lvl;
    nxt    = m_lvl;
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DC; j++) begin
        if (raw_q[raw_q.size() - 3 - j][i] == m_lvl[i]) all_diff = 1'b0;
      end
      if (all_diff) nxt[i] = ~m_lvl[i];
    end
    m_lvl = nxt;
    while (raw_q.size() > DC + 3) void'(raw_q.pop_front());
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] e_lvl, e_pls;
    logic         e_any, e_multi;
    if (rst) begin
      e_lvl = '0; e_pls = '0; e_any = 1'b0; e_multi = 1'b0;
    end else begin
      e_lvl   = m_lvl;
      e_pls   = m_lvl & ~m_prev;
      e_any   = (m_lvl != '0);
      e_multi = ($countones(e_pls) > 1);
    end
    check({tag, "_level"}, 32'(bus.btn_level), 32'(e_lvl));
    check({tag, "_pulse"}, 32'(bus.btn_pulse), 32'(e_pls));
    check({tag, "_any"},   32'(bus.any_held),  32'(e_any));
    check({tag, "_multi"}, 32'(bus.multi),     32'(e_multi));
    for (int i = 0; i < N; i++) pulse_seen[i] += int'(bus.btn_pulse[i]);
    multi_seen += int'(bus.multi);
    any_seen   += int'(bus.any_held);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_edge(bus.btn_in);
    #1;
    check_all(tag);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) pulse_seen[i] = 0;
    multi_seen = 0;
    any_seen   = 0;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (cyc) tick("rst_hold");
    rst = 1'b0;
  endtask

  int hold [N];

  initial begin
    bus.btn_in = '0;
    model_reset();
    clear_counts();
    #1;
    check_all("reset_state");
    repeat (2) tick("reset_hold");
    rst = 1'b0;
    repeat (3) tick("idle");

    // Clean press on channel 0
    clear_counts();
    bus.btn_in = 4'b0001;
    repeat (5) tick("t1");
    check("t1_level_e5", 32'(bus.btn_level[0]), 32'd0);
    tick("t1");
    check("t1_level_e6", 32'(bus.btn_level[0]), 32'd1);
    check("t1_pulse_e6", 32'(bus.btn_pulse), 32'b0001);
    check("t1_multi_e6", 32'(bus.multi), 32'd0);
    repeat (14) tick("t1");
    check("t1_one_pulse", 32'(pulse_seen[0]), 32'd1);

    // Release: level falls after 6 edges, no pulse
    clear_counts();
    bus.btn_in = 4'b0000;
    repeat (5) tick("t3");
    check("t3_level_e5", 32'(bus.btn_level[0]), 32'd1);
    tick("t3");
    check("t3_level_e6", 32'(bus.btn_level[0]), 32'd0);
    repeat (4) tick("t3");
    check("t3_no_pulse", 32'(pulse_seen[0]), 32'd0);

    // Bounce on channel 1: 3 high, 1 low, then held
    clear_counts();
    bus.btn_in = 4'b0010;
    repeat (3) tick("t2");
    bus.btn_in = 4'b0000;
    tick("t2");
    bus.btn_in = 4'b0010;
    repeat (5) tick("t2");
    check("t2_no_early_pulse", 32'(pulse_seen[1]), 32'd0);
    tick("t2");
    check("t2_pulse_e6", 32'(bus.btn_pulse), 32'b0010);
    repeat (4) tick("t2");
    check("t2_one_pulse", 32'(pulse_seen[1]), 32'd1);
    bus.btn_in = 4'b0000;
    repeat (10) tick("t2_rel");

    // Simultaneous press on channels 3 and 2
    clear_counts();
    bus.btn_in = 4'b1100;
    repeat (6) tick("t4");
    check("t4_pulse", 32'(bus.btn_pulse), 32'b1100);
    check("t4_multi", 32'(bus.multi), 32'd1);
    repeat (6) tick("t4");
    check("t4_multi_once", 32'(multi_seen), 32'd1);
    bus.btn_in = 4'b0000;
    repeat (10) tick("t4_rel");

    // Reset mid-count with channel 2 held across it
    clear_counts();
    bus.btn_in = 4'b0100;
    repeat (3) tick("t5_pre");
    do_reset(2);
    repeat (5) tick("t5");
    check("t5_no_pulse_e5", 32'(pulse_seen[2]), 32'd0);
    tick("t5");
    check("t5_pulse_e6", 32'(bus.btn_pulse), 32'b0100);
    repeat (6) tick("t5");
    check("t5_one_pulse", 32'(pulse_seen[2]), 32'd1);
    bus.btn_in = 4'b0000;
    repeat (10) tick("t5_rel");

    // Glitch rejection on channel 3: 1-cycle and 3-cycle blips
    clear_counts();
    bus.btn_in = 4'b1000;
    tick("t6");
    bus.btn_in = 4'b0000;
    repeat (4) tick("t6");
    bus.btn_in = 4'b1000;
    repeat (3) tick("t6");
    bus.btn_in = 4'b0000;
    repeat (8) tick("t6");
    check("t6_no_pulse", 32'(pulse_seen[3]), 32'd0);
    check("t6_no_any", 32'(any_seen), 32'd0);

    // Randomized bounce/hold patterns on all channels, with one mid-run reset
    for (int i = 0; i < N; i++) hold[i] = int'($urandom_range(1, 2 * DC + 2));
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          bus.btn_in[i] = ~bus.btn_in[i];
          hold[i] = int'($urandom_range(1, 2 * DC + 2));
        end
      end
      if (c == 300) do_reset(int'($urandom_range(1, 3)));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
